// File: rtl/exec_unit_pipe_if.sv
// Operand/result bundle with valid-ready handshakes between an issue stage and exec_unit_pipe.
// master drives operands and out_ready; slave (the execute unit) drives results, flags and in_ready.
interface exec_unit_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             alu_src;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] br_target;
  logic             zero;
  logic             ltz;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, op, alu_src, a, b, imm, pc, out_ready,
    input  in_ready, out_valid, result, br_target, zero, ltz, err, busy
  );

  modport slave (
    input  in_valid, op, alu_src, a, b, imm, pc, out_ready,
    output in_ready, out_valid, result, br_target, zero, ltz, err, busy
  );
endinterface

// File: rtl/exec_unit_pipe.sv
// Single-issue ALU execute stage: one registered result per accept, held until consumed.
// Macro EXEC_UNIT_MUL_EN adds an iterative shift-add multiplier (op 14, WIDTH cycles, busy while running).
module exec_unit_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input logic             clk,
  input logic             rst,
  exec_unit_pipe_if.slave bus
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_ROL   = 4'd5;
  localparam logic [3:0] OP_ROR   = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SEQ   = 4'd9;
  localparam logic [3:0] OP_SLT   = 4'd10;
  localparam logic [3:0] OP_SLE   = 4'd11;
  localparam logic [3:0] OP_SCO   = 4'd12;
  localparam logic [3:0] OP_PASSB = 4'd13;

`ifdef EXEC_UNIT_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'd14;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
  logic [WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic {S_IDLE = 1'b0} state_e;
`endif

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d, br_target_q, br_target_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   opb, alu_res, dif, rol_res, ror_res;
  logic [WIDTH:0]     sum, br_sum;
  logic [SHAMT_W-1:0] shamt;
  logic               add_ovf, sub_ovf, alu_err, in_ready, accept;

  always_comb begin
    opb     = bus.alu_src ? bus.imm : bus.b;
    shamt   = opb[SHAMT_W-1:0];
    sum     = {1'b0, bus.a} + {1'b0, opb};
    dif     = opb - bus.a;
    br_sum  = {1'b0, bus.pc} + {1'b0, bus.imm};
    // A shift by WIDTH yields zero, so amount 0 passes a through unchanged.
    rol_res = (bus.a << shamt) | (bus.a >> (WIDTH - int'(shamt)));
    ror_res = (bus.a >> shamt) | (bus.a << (WIDTH - int'(shamt)));
    add_ovf = (bus.a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    sub_ovf = (opb[WIDTH-1] != bus.a[WIDTH-1]) && (dif[WIDTH-1] != opb[WIDTH-1]);
    alu_res = '0;
    alu_err = br_sum[WIDTH];
    case (bus.op)
      OP_ADD:   begin alu_res = sum[WIDTH-1:0]; alu_err = br_sum[WIDTH] | add_ovf; end
      OP_SUB:   begin alu_res = dif;            alu_err = br_sum[WIDTH] | sub_ovf; end
      OP_AND:   begin alu_res = bus.a & opb;    alu_err = 1'b0; end
      OP_OR:    begin alu_res = bus.a | opb;    alu_err = 1'b0; end
      OP_XOR:   begin alu_res = bus.a ^ opb;    alu_err = 1'b0; end
      OP_ROL:   begin alu_res = rol_res;        alu_err = 1'b0; end
      OP_ROR:   begin alu_res = ror_res;        alu_err = 1'b0; end
      OP_SLL:   begin alu_res = bus.a << shamt; alu_err = 1'b0; end
      OP_SRL:   begin alu_res = bus.a >> shamt; alu_err = 1'b0; end
      OP_SEQ:   alu_res = {{(WIDTH-1){1'b0}}, bus.a == opb};
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) <  $signed(opb)};
      OP_SLE:   alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) <= $signed(opb)};
      OP_SCO:   alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
      OP_PASSB: begin alu_res = opb;            alu_err = 1'b0; end
`ifdef EXEC_UNIT_MUL_EN
      OP_MUL:   alu_res = '0;
`endif
      default:  alu_err = 1'b1;
    endcase
  end

  assign in_ready = ~rst & (state_q == S_IDLE) & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    br_target_d = br_target_q;
    err_d       = err_q;
`ifdef EXEC_UNIT_MUL_EN
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
`ifdef EXEC_UNIT_MUL_EN
      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHAMT_W'(1);
        if (cnt_q == '1) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = acc_d;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
`endif
      default: begin
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (accept) begin
          br_target_d = br_sum[WIDTH-1:0];
          err_d       = alu_err;
          result_d    = alu_res;
          out_valid_d = 1'b1;
`ifdef EXEC_UNIT_MUL_EN
          // Multiply result stays invalid until the last shift-add step lands.
          if (bus.op == OP_MUL) begin
            result_d    = result_q;
            out_valid_d = 1'b0;
            state_d     = S_MUL;
            acc_d       = '0;
            mcand_d     = bus.a;
            mplier_d    = opb;
            cnt_d       = '0;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      br_target_q <= '0;
      err_q       <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      br_target_q <= br_target_d;
      err_q       <= err_d;
`ifdef EXEC_UNIT_MUL_EN
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.br_target = br_target_q;
  assign bus.err       = err_q;
  assign bus.zero      = (result_q == '0);
  assign bus.ltz       = result_q[WIDTH-1];
`ifdef EXEC_UNIT_MUL_EN
  assign bus.busy      = (state_q == S_MUL);
`else
  assign bus.busy      = 1'b0;
`endif

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Scoreboard bench for exec_unit_pipe: accepts push model results, an output monitor pops and compares.
module tb_exec_unit_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exec_unit_pipe_if #(.WIDTH(16)) bus ();
  exec_unit_pipe_if #(.WIDTH(32)) bus32 ();

  exec_unit_pipe #(.WIDTH(16), .SHAMT_W(4)) dut   (.clk(clk), .rst(rst), .bus(bus));
  exec_unit_pipe #(.WIDTH(32), .SHAMT_W(5)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  typedef struct {
    longint res;
    longint br;
    bit     err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rdy_rand = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sgn(input int w, input longint x);
    return (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
  endfunction

  function automatic longint rol(input int w, input longint x, input longint n);
    longint m = (longint'(1) << w) - 1;
    return ((x << n) | (x >> (w - n))) & m;
  endfunction

  // Reference: straight arithmetic on wide integers, reduced modulo 2**w.
  function automatic exp_t model(input int w, input int op, input bit src, input longint a,
                                 input longint b, input longint imm, input longint pc);
    exp_t   e;
    longint m   = (longint'(1) << w) - 1;
    longint ob  = src ? imm : b;
    longint n   = ob % w;
    longint sa  = sgn(w, a);
    longint sbv = sgn(w, ob);
    longint hi  = (longint'(1) << (w - 1)) - 1;
    longint lo  = -(longint'(1) << (w - 1));
    longint s;
    bit     cy  = ((pc + imm) >> w) != 0;
    e.br  = (pc + imm) & m;
    e.res = 0;
    e.err = cy;
    case (op)
      0:  begin s = sa + sbv; e.res = (a + ob) & m; e.err = cy || s > hi || s < lo; end
      1:  begin s = sbv - sa; e.res = (ob - a) & m; e.err = cy || s > hi || s < lo; end
      2:  begin e.res = a & ob; e.err = 0; end
      3:  begin e.res = a | ob; e.err = 0; end
      4:  begin e.res = a ^ ob; e.err = 0; end
      5:  begin e.res = rol(w, a, n); e.err = 0; end
      6:  begin e.res = rol(w, a, (w - n) % w); e.err = 0; end
      7:  begin e.res = (a << n) & m; e.err = 0; end
      8:  begin e.res = a >> n; e.err = 0; end
      9:  e.res = (sa == sbv) ? 1 : 0;
      10: e.res = (sa < sbv) ? 1 : 0;
      11: e.res = (sa <= sbv) ? 1 : 0;
      12: e.res = (a + ob) >> w;
      13: begin e.res = ob; e.err = 0; end
`ifdef EXEC_UNIT_MUL_EN
      14: e.res = (a * ob) & m;
`endif
      default: e.err = 1;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = sb[0];
          chk("result", bus.result, e.res);
          chk("br_target", bus.br_target, e.br);
          chk("err", bus.err, e.err);
          chk("zero", bus.zero, (e.res == 0) ? 1 : 0);
          chk("ltz", bus.ltz, (e.res >> (W - 1)) & 1);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(W, int'(bus.op), bus.alu_src, bus.a, bus.b, bus.imm, bus.pc));
`ifndef EXEC_UNIT_MUL_EN
      chk("busy_tied_low", bus.busy, 0);
`endif
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int op, input bit src, input longint a, input longint b,
                       input longint imm, input longint pc);
    int n = 0;
    bus.op = 4'(op);
    bus.alu_src = src;
    bus.a = 16'(a);
    bus.b = 16'(b);
    bus.imm = 16'(imm);
    bus.pc = 16'(pc);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("issue_timeout", n, 0);
      bus.in_valid = 1'b0;
    end else begin
      tick();
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_result"}, bus.result, 0);
    chk({tag, "_br_target"}, bus.br_target, 0);
    chk({tag, "_zero"}, bus.zero, 1);
    chk({tag, "_ltz"}, bus.ltz, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  function automatic longint pick();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 64'h7FFF;
      2:       return 64'h8000;
      3:       return 64'hFFFF;
      4:       return longint'($urandom_range(0, 15));
      default: return longint'($urandom & 32'hFFFF);
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog_expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int     n;
    bit     seen;
    exp_t   e32;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = 4'd0;
    bus.alu_src = 1'b0;
    bus.a = 16'h0001;
    bus.b = 16'h0001;
    bus.imm = 16'h0;
    bus.pc = 16'h0;
    bus.out_ready = 1'b1;
    bus32.in_valid = 1'b0;
    bus32.op = 4'd0;
    bus32.alu_src = 1'b0;
    bus32.a = '0;
    bus32.b = '0;
    bus32.imm = '0;
    bus32.pc = '0;
    bus32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_reset", bus.in_ready, 0);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("por");

    // Signed overflow on ADD, result visible one cycle after accept.
    tick();
    issue(0, 0, 16'h7FFF, 16'h0001, 0, 0);
    @(negedge clk);
    chk("add_ovf_valid", bus.out_valid, 1);
    chk("add_ovf_result", bus.result, 16'h8000);
    chk("add_ovf_err", bus.err, 1);
    chk("add_ovf_ltz", bus.ltz, 1);

    tick();
    issue(6, 1, 16'h0001, 0, 16'h0001, 0);
    @(negedge clk);
    chk("ror1_result", bus.result, 16'h8000);
    tick();
    issue(5, 1, 16'hA5A5, 0, 0, 0);
    @(negedge clk);
    chk("rol0_result", bus.result, 16'hA5A5);

    // Back-to-back with the consumer stalled for three cycles.
    tick();
    bus.out_ready = 1'b0;
    issue(0, 0, 16'h1234, 16'h0101, 0, 0);
    fork
      issue(1, 0, 16'h0003, 16'h0010, 0, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 0);
          chk("stall_out_valid", bus.out_valid, 1);
        end
        tick();
        bus.out_ready = 1'b1;
      end
    join
    issue(10, 0, 16'hFFFF, 16'h0001, 0, 0);
    @(negedge clk);
    chk("b2b_no_bubble", bus.out_valid, 1);

`ifdef EXEC_UNIT_MUL_EN
    tick();
    issue(14, 0, 16'h0003, 16'h0005, 0, 0);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !bus.out_valid; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      if (bus.in_ready) seen = 1'b1;
    end
    chk("mul_busy_cycles", n, 16);
    chk("mul_in_ready_low", seen, 0);
    chk("mul_result", bus.result, 16'h000F);

    tick();
    issue(14, 0, 16'h0007, 16'h0009, 0, 0);
    repeat (4) @(negedge clk);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("mul_abort");
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mul_abort_no_result", seen, 0);
`else
    tick();
    issue(14, 0, 16'h0003, 16'h0005, 0, 0);
    @(negedge clk);
    chk("op14_result", bus.result, 0);
    chk("op14_err", bus.err, 1);
`endif

    // Reset while a result is waiting for the consumer drops it.
    tick();
    bus.out_ready = 1'b0;
    issue(0, 0, 16'h0001, 16'h0002, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_reset_state("rst_pending");

    // Branch target wrap at 32 bits.
    tick();
    bus32.op = 4'd0;
    bus32.imm = 32'h00000004;
    bus32.pc = 32'hFFFFFFFE;
    bus32.in_valid = 1'b1;
    @(negedge clk);
    chk("w32_in_ready", bus32.in_ready, 1);
    tick();
    bus32.in_valid = 1'b0;
    e32 = model(32, 0, 0, 0, 0, 32'h00000004, 32'hFFFFFFFE);
    @(negedge clk);
    chk("w32_out_valid", bus32.out_valid, 1);
    chk("w32_br_target", bus32.br_target, 32'h00000002);
    chk("w32_err", bus32.err, 1);
    chk("w32_result", bus32.result, e32.res);

    tick();
    rdy_rand = 1'b1;
    for (int t = 0; t < 300; t++) begin
      issue($urandom_range(0, 15), 1'($urandom_range(0, 1)), pick(), pick(), pick(), pick());
      if ($urandom_range(0, 4) == 0) tick();
    end

    @(negedge clk);
    rdy_rand = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
